// File: rtl/icache_fill_controller_if.sv
// Fetch-side and memory-side signal bundle for icache_fill_controller.
// slave is the cache; master is the fetch stage plus backing memory.
interface icache_fill_controller_if;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        fetch_ready;
  logic [31:0] instruction;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  modport master (
    output fetch_req, fetch_pc, flush, mem_ack, mem_data,
    input  fetch_ready, instruction, busy, mem_req, mem_addr
  );

  modport slave (
    input  fetch_req, fetch_pc, flush, mem_ack, mem_data,
    output fetch_ready, instruction, busy, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_fill_controller.sv
// Direct-mapped I-cache with miss refill and bounded memory wait.
// Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache_fill_controller #(
  parameter int SETS    = 16,
  parameter int TIMEOUT = 255
) (
  input logic clock,
  input logic reset,
  icache_fill_controller_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 3 - IDX_W;
  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, LOOKUP, MEM_WAIT, RESPOND
  } state_t;

  state_t state, state_d;

  logic [31:0]      pc_q, pc_d;
  logic             flush_pend, pend_d;
  logic [15:0]      wait_cnt, cnt_d;
  logic [SETS-1:0]  valid, valid_d;
  logic             ready_d, req_d, fill_we;
  logic [31:0]      instr_d, addr_d;

  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             expired;

  assign idx     = pc_q[3 +: IDX_W];
  assign tag     = pc_q[31 -: TAG_W];
  assign hit     = valid[idx] && (tags[idx] == tag);
  assign expired = (wait_cnt == LAST);

  // State register plus all registered outputs and control state
  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= IDLE;
      pc_q            <= '0;
      flush_pend      <= 1'b0;
      wait_cnt        <= '0;
      valid           <= '0;
      bus.fetch_ready <= 1'b0;
      bus.instruction <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_addr    <= '0;
      bus.busy        <= 1'b0;
    end else begin
      state           <= state_d;
      pc_q            <= pc_d;
      flush_pend      <= pend_d;
      wait_cnt        <= cnt_d;
      valid           <= valid_d;
      bus.fetch_ready <= ready_d;
      bus.instruction <= instr_d;
      bus.mem_req     <= req_d;
      bus.mem_addr    <= addr_d;
      bus.busy        <= (state_d != IDLE);
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:     if (!bus.flush && bus.fetch_req) state_d = LOOKUP;
      LOOKUP:   state_d = hit ? RESPOND : MEM_WAIT;
      MEM_WAIT: if (bus.mem_ack || expired) state_d = RESPOND;
      RESPOND:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values of outputs, valid bits, wait counter and flush pending
  always_comb begin
    pc_d    = pc_q;
    ready_d = 1'b0;
    instr_d = bus.instruction;
    req_d   = bus.mem_req;
    addr_d  = bus.mem_addr;
    cnt_d   = wait_cnt;
    pend_d  = flush_pend | (bus.flush && state != IDLE);
    valid_d = valid;
    fill_we = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.flush) valid_d = '0;
        else if (bus.fetch_req) pc_d = bus.fetch_pc;
      end
      LOOKUP: begin
        if (hit) begin
          instr_d = data[idx];
          ready_d = 1'b1;
        end else begin
          req_d  = 1'b1;
          addr_d = pc_q & ~32'h7;
          cnt_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ack) begin
          fill_we      = 1'b1;
          valid_d[idx] = 1'b1;
          req_d        = 1'b0;
          instr_d      = bus.mem_data;
          ready_d      = 1'b1;
        end else if (expired) begin
          req_d   = 1'b0;
          instr_d = 32'hDEAD_BEEF;
          ready_d = 1'b1;
        end else begin
          cnt_d = wait_cnt + 16'd1;
        end
      end
      RESPOND: begin
        if (pend_d) begin
          valid_d = '0;
          pend_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Line fill; reset in the same cycle abandons the write
  always_ff @(posedge clock) begin
    if (reset && fill_we) begin
      tags[idx] <= tag;
      data[idx] <= bus.mem_data;
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating hit/miss counters, updated once per lookup
  always_ff @(posedge clock) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule
